// File: rtl/furv_pkg.sv
// furv_pkg -- shared types and constants for the FURV data-bus bridge.
//
// Contents:
//   dbus_state_t           bridge sequencer states (IDLE / WRITE / READ)
//   wbuf_entry_t           one posted write: {word address, byte lanes, data}
//   WBUF_ENTRY_W           width of a packed write-buffer entry
//   FAILED_READ_DATA       value returned to the core when a read fails
//   TIMEOUT_CYCLES_DEFAULT default bus-cycle limit for the optional timeout
package furv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } dbus_state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } wbuf_entry_t;

  localparam int unsigned WBUF_ENTRY_W = $bits(wbuf_entry_t);

  localparam logic [31:0] FAILED_READ_DATA = 32'h0000_0000;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/furv_wbuf.sv
// furv_wbuf -- synchronous FIFO holding posted writes.
//
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate occupancy counter. Storage is not reset; only the
// pointers are, which is enough to make the buffer empty.
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   i_push      write i_data at the tail (caller guarantees room, see below)
//   i_pop       discard the head entry (caller guarantees not empty)
//   i_data      entry to push
//   o_data      current head entry (valid while o_empty is 0)
//   o_full      all DEPTH entries occupied
//   o_empty     no entries occupied
//
// A push while full is legal only together with a pop: the head slot is read
// combinationally this cycle and overwritten at the same edge.
module furv_wbuf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  // Same slot index but opposite wrap bits: the writer has lapped the reader.
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/furv_dbus.sv
// furv_dbus -- bridge from the FURV core data port to a Wishbone classic master.
//
// Writes are posted into a small FIFO (furv_wbuf) and never acknowledged to
// the core. A single read may be pending; it is issued only once every
// buffered write has drained, so the bus sees accesses in program order.
// Each Wishbone transaction is a single classic cycle; one IDLE cycle always
// separates two transactions.
//
// Handshake: the core request is level-sensitive. A request is accepted on a
// rising edge with core_mem=1 while no request is marked taken; taken stays
// set while core_mem remains high and clears on the first edge it is low.
// The Wishbone side holds cyc/stb and all address/data/control stable from
// the start of a transaction until the edge on which ack, err (or timeout)
// is sampled.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   core_mem, core_mem_write   request valid (level), 1 = write / 0 = read
//   core_addr, core_sel        word address, byte lanes
//   core_data_out              write data, already shifted to lanes
//   core_data_in               last read data (0 after a failed read)
//   core_read_ack              one-cycle pulse per completed read
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o   Wishbone master
//   wb_dat_i, wb_ack_i, wb_err_i                                Wishbone slave response
//   err_clr                    clears sticky flags (a same-cycle set wins)
//   bus_err                    sticky: a transaction ended by err or timeout
//   wbuf_ovf                   sticky: a write was dropped on a full buffer
//
// Build option: define FURV_DBUS_TIMEOUT_EN to terminate any transaction that
// receives neither ack nor err within TIMEOUT_CYCLES cycles; the timeout is
// handled exactly like wb_err_i. Without it the bridge waits indefinitely.
module furv_dbus
  import furv_pkg::*;
#(
  parameter int unsigned WBUF_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_mem,
  input  logic        core_mem_write,
  input  logic [29:0] core_addr,
  input  logic [3:0]  core_sel,
  input  logic [31:0] core_data_out,
  output logic [31:0] core_data_in,
  output logic        core_read_ack,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [29:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        err_clr,
  output logic        bus_err,
  output logic        wbuf_ovf
);

  dbus_state_t r_state;
  dbus_state_t w_state_nxt;

  logic        r_taken;
  logic        r_rd_pend;
  logic [29:0] r_rd_addr;
  logic [3:0]  r_rd_sel;
  logic [31:0] r_core_data_in;
  logic        r_read_ack;
  logic        r_bus_err;
  logic        r_wbuf_ovf;

  logic        w_accept;
  logic        w_acc_wr;
  logic        w_acc_rd;
  logic        w_busy;
  logic        w_timeout;
  logic        w_term;
  logic        w_term_err;
  logic        w_rd_done;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_full;
  logic        w_empty;
  wbuf_entry_t w_new_entry;
  wbuf_entry_t w_head;

  // Core request acceptance
  assign w_accept = core_mem & ~r_taken;
  assign w_acc_wr = w_accept & core_mem_write;
  assign w_acc_rd = w_accept & ~core_mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_taken <= 1'b0;
    else        r_taken <= core_mem;  // set on acceptance, held while core_mem stays high
  end

  // Transaction termination
  assign w_busy     = (r_state != ST_IDLE);
  assign w_term     = w_busy & (wb_ack_i | wb_err_i | w_timeout);
  // err wins over a simultaneous ack: the access is reported as failed.
  assign w_term_err = w_busy & (wb_err_i | w_timeout);
  assign w_rd_done  = (r_state == ST_READ) & w_term;

`ifdef FURV_DBUS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_tmo_cnt <= '0;
    else if (!w_busy || w_term)    r_tmo_cnt <= '0;
    else                           r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  // Count starts at 0 in the first bus cycle, so the limit is reached in
  // cycle TIMEOUT_CYCLES and the transaction ends on that cycle's edge.
  assign w_timeout = w_busy && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Write buffer: pop-before-push, so a full buffer that is retiring its
  // head on this edge still accepts the new write.
  assign w_pop    = (r_state == ST_WRITE) & w_term;
  assign w_push   = w_acc_wr & (~w_full | w_pop);
  assign w_drop   = w_acc_wr & w_full & ~w_pop;

  assign w_new_entry.addr = core_addr;
  assign w_new_entry.sel  = core_sel;
  assign w_new_entry.data = core_data_out;

  furv_wbuf #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (WBUF_ENTRY_W)
  ) u_wbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_new_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Pending read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_rd_addr <= '0;
      r_rd_sel  <= '0;
    end else if (w_acc_rd) begin
      r_rd_pend <= 1'b1;
      r_rd_addr <= core_addr;
      r_rd_sel  <= core_sel;
    end else if (w_rd_done) begin
      r_rd_pend <= 1'b0;
    end
  end

  // Sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_adr_o    = '0;
    wb_sel_o    = '0;
    wb_dat_o    = '0;
    case (r_state)
      ST_IDLE: begin
        // Buffered writes first: a read never overtakes an earlier write.
        if (!w_empty)       w_state_nxt = ST_WRITE;
        else if (r_rd_pend) w_state_nxt = ST_READ;
      end
      ST_WRITE: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = w_head.addr;
        wb_sel_o = w_head.sel;
        wb_dat_o = w_head.data;
        if (w_term) w_state_nxt = ST_IDLE;
      end
      ST_READ: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_adr_o = r_rd_addr;
        wb_sel_o = r_rd_sel;
        if (w_term) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read return to the core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_data_in <= '0;
      r_read_ack     <= 1'b0;
    end else begin
      r_read_ack <= w_rd_done;
      if (w_rd_done) r_core_data_in <= w_term_err ? FAILED_READ_DATA : wb_dat_i;
    end
  end

  // Sticky flags: a set event on the same edge beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_err  <= 1'b0;
      r_wbuf_ovf <= 1'b0;
    end else begin
      if (w_term_err)   r_bus_err <= 1'b1;
      else if (err_clr) r_bus_err <= 1'b0;
      if (w_drop)       r_wbuf_ovf <= 1'b1;
      else if (err_clr) r_wbuf_ovf <= 1'b0;
    end
  end

  assign core_data_in  = r_core_data_in;
  assign core_read_ack = r_read_ack;
  assign bus_err       = r_bus_err;
  assign wbuf_ovf      = r_wbuf_ovf;

endmodule

// File: tb/tb_furv_dbus.sv
// tb_furv_dbus -- self-checking bench for furv_dbus.
//
// The reference model is a transaction list: every core access that must
// reach the bus is appended to exp_q in program order, and a behavioural
// Wishbone slave appends what it actually completes to obs_q. Read data,
// read latency and sticky flags are predicted from the access rules.
// Build with FURV_DBUS_TIMEOUT_EN defined to run the timeout scenario.
module tb_furv_dbus;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 8;

  logic        clk;
  logic        rst_n;
  logic        core_mem;
  logic        core_mem_write;
  logic [29:0] core_addr;
  logic [3:0]  core_sel;
  logic [31:0] core_data_out;
  logic [31:0] core_data_in;
  logic        core_read_ack;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [29:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        err_clr;
  logic        bus_err;
  logic        wbuf_ovf;

  furv_dbus #(
    .WBUF_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_mem       (core_mem),
    .core_mem_write (core_mem_write),
    .core_addr      (core_addr),
    .core_sel       (core_sel),
    .core_data_out  (core_data_out),
    .core_data_in   (core_data_in),
    .core_read_ack  (core_read_ack),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_adr_o       (wb_adr_o),
    .wb_sel_o       (wb_sel_o),
    .wb_dat_o       (wb_dat_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i),
    .wb_err_i       (wb_err_i),
    .err_clr        (err_clr),
    .bus_err        (bus_err),
    .wbuf_ovf       (wbuf_ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;
  int n_acks   = 0;
  int exp_reads = 0;
  logic [66:0] exp_q[$];
  logic [66:0] obs_q[$];

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural Wishbone slave ----------------
  int          slave_delay = 0;
  bit          slave_stall = 0;
  bit          slave_err   = 0;
  logic [31:0] slave_rdata = '0;
  int          last_txn_cycles = 0;

  function automatic logic [66:0] bus_view();
    // Data lanes matter only for writes.
    return {wb_we_o, wb_adr_o, wb_sel_o, (wb_we_o ? wb_dat_o : 32'h0)};
  endfunction

  initial begin
    int          wcnt;
    bit          in_ack;
    logic [66:0] first;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    wcnt     = 0;
    in_ack   = 0;
    first    = '0;
    forever begin
      @(negedge clk);
      if (in_ack) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        in_ack   = 0;
        wcnt     = 0;
        check("idle_gap", wb_cyc_o, 1'b0);
      end else if (wb_cyc_o === 1'b1 && rst_n === 1'b1) begin
        if (wcnt == 0) first = bus_view();
        else           check("wb_stable", bus_view(), first);
        check("stb_with_cyc", wb_stb_o, 1'b1);
        if (!slave_stall && wcnt >= slave_delay) begin
          if (slave_err) wb_err_i = 1'b1;
          else           wb_ack_i = 1'b1;
          wb_dat_i = wb_we_o ? $urandom : slave_rdata;
          obs_q.push_back(bus_view());
          in_ack = 1;
        end
        wcnt++;
      end else begin
        if (wcnt > 0) last_txn_cycles = wcnt;
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (core_read_ack === 1'b1) n_acks++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic core_write(input logic [29:0] a, input logic [3:0] s,
                            input logic [31:0] d, input bit kept);
    @(negedge clk);
    core_mem       = 1'b1;
    core_mem_write = 1'b1;
    core_addr      = a;
    core_sel       = s;
    core_data_out  = d;
    if (kept) exp_q.push_back({1'b1, a, s, d});
    @(negedge clk);
    core_mem = 1'b0;
  endtask

  // Holds the request until core_read_ack, like the core does.
  task automatic core_read(input logic [29:0] a, input logic [3:0] s,
                           input logic [31:0] rdata, input logic [31:0] exp_d,
                           input bit on_bus, input int exp_lat);
    int cyc_n;
    bit got;
    slave_rdata = rdata;
    @(negedge clk);
    core_mem       = 1'b1;
    core_mem_write = 1'b0;
    core_addr      = a;
    core_sel       = s;
    if (on_bus) exp_q.push_back({1'b0, a, s, 32'h0});
    got   = 0;
    cyc_n = 0;
    while (!got && cyc_n < 300) begin
      @(negedge clk);
      cyc_n++;
      if (core_read_ack === 1'b1) got = 1;
    end
    check("rd_ack_seen", got, 1'b1);
    if (exp_lat > 0) check("rd_latency", cyc_n, exp_lat);
    check("rd_data", core_data_in, exp_d);
    core_mem = 1'b0;
    exp_reads++;
    @(negedge clk);
    check("rd_ack_single", core_read_ack, 1'b0);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet;
    int n;
    quiet = 0;
    n     = 0;
    while (quiet < 3 && n < 500) begin
      @(negedge clk);
      n++;
      quiet = (wb_cyc_o === 1'b0) ? quiet + 1 : 0;
    end
    check("idle_reached", (quiet >= 3), 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] last_rd;
    logic [29:0] a;
    logic [3:0]  s;
    int          occ;
    int          nw;
    bit          saw;

    rst_n          = 1'b0;
    core_mem       = 1'b0;
    core_mem_write = 1'b0;
    core_addr      = '0;
    core_sel       = '0;
    core_data_out  = '0;
    err_clr        = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_adr", wb_adr_o, 30'h0);
    check("rst_sel", wb_sel_o, 4'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_data_in", core_data_in, 32'h0);
    check("rst_read_ack", core_read_ack, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_ovf", wbuf_ovf, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read 0x100, slave answers two cycles into the cycle
    slave_delay = 2;
    core_read(30'h100, 4'hF, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0);
    last_rd = 32'hCAFE_F00D;

    // Minimum read latency on an empty buffer: request, READ, ack, pulse
    slave_delay = 0;
    d = $urandom;
    core_read(30'($urandom), 4'($urandom_range(1, 15)), d, d, 1, 3);
    last_rd = d;

    // Three posted writes then a read: bus order must follow program order
    core_write(30'h10, 4'hF, $urandom, 1);
    core_write(30'h11, 4'h3, $urandom, 1);
    core_write(30'h12, 4'hC, $urandom, 1);
    check("data_in_held", core_data_in, last_rd);
    d = $urandom;
    core_read(30'h10, 4'hF, d, d, 1, 0);
    last_rd = d;

    // Random bursts of up to DEPTH writes followed by a read
    for (int it = 0; it < 20; it++) begin
      slave_delay = $urandom_range(0, 3);
      nw = $urandom_range(0, DEPTH);
      for (int k = 0; k < nw; k++)
        core_write(30'($urandom), 4'($urandom_range(1, 15)), $urandom, 1);
      check("data_in_held_rand", core_data_in, last_rd);
      d = $urandom;
      core_read(30'($urandom), 4'($urandom_range(1, 15)), d, d, 1, 0);
      last_rd = d;
    end
    check("no_ovf_rand", wbuf_ovf, 1'b0);
    check("no_err_rand", bus_err, 1'b0);

    // Read terminated by wb_err_i returns zero and sets bus_err
    slave_delay = 1;
    slave_err   = 1;
    core_read(30'h2A, 4'hF, 32'hDEAD_BEEF, 32'h0, 1, 0);
    slave_err   = 0;
    check("err_bus_err", bus_err, 1'b1);
    pulse_err_clr();
    check("err_cleared", bus_err, 1'b0);

`ifndef FURV_DBUS_TIMEOUT_EN
    // Stalled slave: DEPTH writes fit, further ones are dropped
    slave_stall = 1;
    occ = 0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      core_write(30'h40 + 30'(k), 4'hF, $urandom, (occ < DEPTH));
      if (occ < DEPTH) occ++;
      if (k == DEPTH - 1) check("ovf_not_yet", wbuf_ovf, 1'b0);
    end
    check("ovf_set", wbuf_ovf, 1'b1);
    pulse_err_clr();
    check("ovf_cleared", wbuf_ovf, 1'b0);
    // Drop and clear on the same edge: the set wins
    @(negedge clk);
    core_mem       = 1'b1;
    core_mem_write = 1'b1;
    core_addr      = 30'h7F;
    core_sel       = 4'hF;
    core_data_out  = $urandom;
    err_clr        = 1'b1;
    @(negedge clk);
    core_mem = 1'b0;
    err_clr  = 1'b0;
    check("ovf_set_wins", wbuf_ovf, 1'b1);
    pulse_err_clr();
    check("ovf_cleared2", wbuf_ovf, 1'b0);
    slave_stall = 0;
    slave_delay = 0;
    d = $urandom;
    core_read(30'h50, 4'h1, d, d, 1, 0);
    check("ovf_no_bus_err", bus_err, 1'b0);
`else
    // Silent slave: transaction times out after TMO cycles and reads zero
    slave_stall = 1;
    core_read(30'h60, 4'hF, 32'h1234_5678, 32'h0, 0, 0);
    check("tmo_cycles", last_txn_cycles, TMO);
    check("tmo_bus_err", bus_err, 1'b1);
    slave_stall = 0;
    pulse_err_clr();
    check("tmo_err_cleared", bus_err, 1'b0);
`endif

    // Reset in the middle of a read: cycle abandoned, never acknowledged
    slave_stall = 1;
    @(negedge clk);
    core_mem       = 1'b1;
    core_mem_write = 1'b0;
    core_addr      = 30'h77;
    core_sel       = 4'hF;
    saw = 0;
    for (int k = 0; k < 20 && !saw; k++) begin
      @(negedge clk);
      if (wb_cyc_o === 1'b1) saw = 1;
    end
    check("mid_rd_cyc_up", saw, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cyc", wb_cyc_o, 1'b0);
    check("rst_mid_stb", wb_stb_o, 1'b0);
    check("rst_mid_ack", core_read_ack, 1'b0);
    core_mem    = 1'b0;
    slave_stall = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (core_read_ack === 1'b1 || wb_cyc_o === 1'b1) saw = 1;
    end
    check("post_rst_quiet", saw, 1'b0);
    check("post_rst_data_in", core_data_in, 32'h0);

    // Bridge still works after reset; the buffer must have come back empty
    slave_delay = 1;
    d = $urandom;
    core_read(30'h99, 4'h6, d, d, 1, 0);

    // Final comparison of the bus transaction list
    wait_idle();
    check("txn_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("txn_order", obs_q[i], exp_q[i]);
    check("read_ack_count", n_acks, exp_reads);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/furv_dbus.md
FURV_DBUS -- requirements
Module: furv_dbus

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 4, write-buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, bus-cycle limit when the timeout feature is compiled in.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_mem  in  1  core request valid (level).
- core_mem_write  in  1  1 = write, 0 = read.
- core_addr  in  30  word address.
- core_sel  in  4  byte lanes.
- core_data_out  in  32  write data, pre-shifted to lanes.
- core_data_in  out  32  read data.
- core_read_ack  out  1  read-complete pulse.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone classic master controls.
- wb_adr_o  out  30; wb_sel_o  out  4; wb_dat_o  out  32.
- wb_dat_i  in  32; wb_ack_i  in  1; wb_err_i  in  1.
- err_clr  in  1  clears sticky flags.
- bus_err  out  1  sticky: err or timeout seen.
- wbuf_ovf  out  1  sticky: write dropped on full buffer.

Function
REQ-004 SHALL accept a request on a rising edge where core_mem=1 and no request is already marked taken; taken SHALL set on acceptance and clear on any edge where core_mem=0.
REQ-005 SHALL push an accepted write {addr, sel, data} into the write buffer on the acceptance edge; writes are posted and never acknowledged to the core.
REQ-006 SHALL, on a write acceptance while the buffer is full and not popping that edge, drop the write and set wbuf_ovf; a pop on the same edge SHALL make room (pop-before-push).
REQ-007 SHALL latch an accepted read into a single pending-read register.
REQ-008 SHALL implement FSM IDLE, WRITE, READ: IDLE->WRITE when buffer non-empty; IDLE->READ when buffer empty and read pending; WRITE/READ->IDLE on termination (ack, err, or timeout).
REQ-009 SHALL drain all buffered writes before issuing a pending read (program order).
REQ-010 SHALL assert wb_cyc_o=wb_stb_o=1 with stable adr/sel/we/dat throughout WRITE and READ, 0 in IDLE; one IDLE cycle separates transactions.
REQ-011 SHALL pop the buffer head on WRITE termination.
REQ-012 SHALL, on READ termination by ack, register wb_dat_i into core_data_in and pulse core_read_ack for exactly one cycle on the following edge, then clear the pending read.
REQ-013 SHALL, on termination by wb_err_i (same handling as ack), set bus_err; a failed read SHALL return 32'h0 with core_read_ack pulsed normally.
REQ-014 SHALL hold core_data_in stable between read completions.
REQ-015 SHALL give err_clr priority below a same-cycle set event (set wins).
REQ-016 SHALL achieve minimum read latency (empty buffer): acceptance edge +1 READ, ack at earliest same cycle, core_read_ack next edge.

Reset
REQ-017 SHALL, on rst_n low, asynchronously: FSM IDLE, buffer empty, pending read and taken cleared, all outputs 0 (core_data_in, wb_* and flags included).
REQ-018 SHALL abandon any in-flight Wishbone cycle on reset mid-transaction (cyc drops immediately); the dropped read SHALL never be acknowledged.

Configuration
REQ-019 SHALL, with FURV_DBUS_TIMEOUT_EN defined, count cycles in WRITE/READ and terminate at TIMEOUT_CYCLES with no ack, treated as err (REQ-013).
REQ-020 SHALL, without FURV_DBUS_TIMEOUT_EN, wait indefinitely for ack/err; no counter logic present.

Structure
REQ-021 SHALL take the FSM state enum, the failed-read value 32'h0 and the TIMEOUT_CYCLES default from package furv_pkg.
REQ-022 SHALL place the write buffer in sub-module furv_wbuf (synchronous FIFO with full/empty, push/pop, wrap-around pointers).

Verification
REQ-023 Read 0x100, slave acks 2 cycles after stb, data 0xCAFEF00D -> single core_read_ack, core_data_in=0xCAFEF00D.
REQ-024 Writes to 0x10, 0x11, 0x12 back-to-back then read 0x10 -> three Wishbone writes in order before the read cycle.
REQ-025 Slave stalls (no ack), 5 writes with WBUF_DEPTH=4 -> fifth dropped, wbuf_ovf=1; err_clr clears it.
REQ-026 Read, slave asserts wb_err_i -> core_data_in=0, core_read_ack pulse, bus_err=1.
REQ-027 FURV_DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, silent slave -> cyc drops after 8 cycles, read acks with 0, bus_err=1.
REQ-028 rst_n low mid-READ -> cyc/stb 0 immediately, no core_read_ack, buffer empty after release.
